// File: rtl/sd_spi_responder.sv
// ---------------------------------------------------------------------------
// sd_spi_responder
//   SD-card SPI-mode responder. It decodes 6-byte command frames and answers
//   CMD0/8/55/ACMD41/58/17. A CMD17 after initialisation streams one 512-byte
//   block that is fetched byte by byte from an external storage port.
//
// Ports
//   clk_clk      : system clock; all logic runs on the rising edge
//   reset_reset  : asynchronous, active-high reset
//   spi_sclk     : SPI clock from the master (mode 0), oversampled by clk_clk
//   spi_cs_n     : chip select, active low; a high level aborts any transfer
//   spi_mosi     : master-out data, MSB first
//   spi_miso     : responder-out data; idles at 1
//   rd_lba       : block address latched from the CMD17 argument
//   rd_index     : byte index within the block (0..511)
//   rd_data      : storage byte at rd_lba/rd_index, valid 1 clk after address
//   card_ready   : initialisation complete
//   busy         : CMD17 transfer in progress (R1 through the last CRC bit)
//
// State table (each state names the byte that is loaded on the next SCLK fall)
//   state  | meaning
//   RX_CMD | receiving a command frame, MISO idle high
//   NCR    | one 0xFF byte before the response
//   RESP   | response bytes (R1, optionally 4 more)
//   GAP    | one 0xFF byte between CMD17 R1 and the data token
//   TOKEN  | start-block token 0xFE
//   DATA   | 512 data bytes from rd_data
//   CRC    | two 0xFF CRC bytes
// ---------------------------------------------------------------------------
module sd_spi_responder (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [31:0] rd_lba,
    output logic [8:0]  rd_index,
    input  logic [7:0]  rd_data,
    output logic        card_ready,
    output logic        busy
);

    typedef enum logic [2:0] {
        RX_CMD = 3'd0,
        NCR    = 3'd1,
        RESP   = 3'd2,
        GAP    = 3'd3,
        TOKEN  = 3'd4,
        DATA   = 3'd5,
        CRC    = 3'd6
    } state_t;

    // Synchronizers; sclk has a third stage so edges are seen on stage 2.
    logic [2:0]  sclk_sync_q;
    logic [1:0]  cs_sync_q;
    logic [1:0]  mosi_sync_q;

    state_t      state_q;
    logic [2:0]  bit_cnt_q;
    logic [6:0]  rx_sr_q;
    logic [2:0]  frame_cnt_q;
    logic [5:0]  cmd_idx_q;
    logic [31:0] arg_q;

    logic [39:0] resp_q;
    logic [2:0]  resp_left_q;
    logic        data_cmd_q;
    logic        data_last_q;
    logic        crc_last_q;

    logic        load_pend_q;
    logic        tx_act_q;
    logic [7:0]  tx_sr_q;
    logic        miso_q;

    logic        card_ready_q;
    logic        app_cmd_q;
    logic        acmd41_seen_q;
    logic        busy_q;
    logic [31:0] rd_lba_q;
    logic [8:0]  rd_index_q;

    logic        sclk_rise;
    logic        sclk_fall;
    logic        cs_active;
    logic        byte_done;
    logic [7:0]  rx_byte_d;
    logic [7:0]  tx_byte_d;
    logic [7:0]  not_ready_r1;

    logic [39:0] resp_d;
    logic [2:0]  resp_len_d;
    logic        data_cmd_d;
    logic        card_ready_d;
    logic        app_cmd_d;
    logic        acmd41_seen_d;
    logic [31:0] rd_lba_d;

    assign sclk_rise    = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall    = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_active    = ~cs_sync_q[1];
    assign byte_done    = sclk_rise && (bit_cnt_q == 3'd7);
    assign rx_byte_d    = {rx_sr_q, mosi_sync_q[1]};
    assign not_ready_r1 = {7'b0, ~card_ready_q};

    always_comb begin
        tx_byte_d = 8'hFF;
        case (state_q)
            RESP:    tx_byte_d = resp_q[39:32];
            TOKEN:   tx_byte_d = 8'hFE;
            DATA:    tx_byte_d = rd_data;
            default: tx_byte_d = 8'hFF;
        endcase
    end

    // Response and side effects of the frame just completed. Unused response
    // slots are padded with 0xFF and never sent.
    always_comb begin
        resp_d        = {8'h04 | not_ready_r1, 32'hFFFF_FFFF};
        resp_len_d    = 3'd1;
        data_cmd_d    = 1'b0;
        card_ready_d  = card_ready_q;
        app_cmd_d     = 1'b0;
        acmd41_seen_d = acmd41_seen_q;
        rd_lba_d      = rd_lba_q;
        case (cmd_idx_q)
            6'd0: begin
                resp_d        = {8'h01, 32'hFFFF_FFFF};
                card_ready_d  = 1'b0;
                acmd41_seen_d = 1'b0;
            end
            6'd8: begin
                resp_d     = {not_ready_r1, 16'h0000, 4'h0, arg_q[11:0]};
                resp_len_d = 3'd5;
            end
            6'd55: begin
                resp_d    = {not_ready_r1, 32'hFFFF_FFFF};
                app_cmd_d = 1'b1;
            end
            6'd41: begin
                if (app_cmd_q) begin
                    if (!acmd41_seen_q) begin
                        resp_d        = {8'h01, 32'hFFFF_FFFF};
                        acmd41_seen_d = 1'b1;
                    end else begin
                        resp_d       = {8'h00, 32'hFFFF_FFFF};
                        card_ready_d = 1'b1;
                    end
                end
            end
            6'd58: begin
                resp_d     = {not_ready_r1, 32'hC0FF_8000};
                resp_len_d = 3'd5;
            end
            6'd17: begin
                if (card_ready_q) begin
                    resp_d     = {8'h00, 32'hFFFF_FFFF};
                    data_cmd_d = 1'b1;
                    rd_lba_d   = arg_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sclk_sync_q   <= 3'b000;
            cs_sync_q     <= 2'b11;
            mosi_sync_q   <= 2'b11;
            state_q       <= RX_CMD;
            bit_cnt_q     <= 3'd0;
            rx_sr_q       <= 7'd0;
            frame_cnt_q   <= 3'd0;
            cmd_idx_q     <= 6'd0;
            arg_q         <= 32'd0;
            resp_q        <= 40'hFF_FFFF_FFFF;
            resp_left_q   <= 3'd0;
            data_cmd_q    <= 1'b0;
            data_last_q   <= 1'b0;
            crc_last_q    <= 1'b0;
            load_pend_q   <= 1'b0;
            tx_act_q      <= 1'b0;
            tx_sr_q       <= 8'hFF;
            miso_q        <= 1'b1;
            card_ready_q  <= 1'b0;
            app_cmd_q     <= 1'b0;
            acmd41_seen_q <= 1'b0;
            busy_q        <= 1'b0;
            rd_lba_q      <= 32'd0;
            rd_index_q    <= 9'd0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};

            if (!cs_active) begin
                // Abort; card_ready and app_cmd survive a deselect.
                state_q     <= RX_CMD;
                bit_cnt_q   <= 3'd0;
                frame_cnt_q <= 3'd0;
                load_pend_q <= 1'b0;
                tx_act_q    <= 1'b0;
                miso_q      <= 1'b1;
                busy_q      <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    rx_sr_q   <= rx_byte_d[6:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end

                // Byte boundary: pick the next state; the byte itself is
                // loaded on the following fall. MOSI is only decoded in RX_CMD.
                if (byte_done) begin
                    case (state_q)
                        RX_CMD: begin
                            if (frame_cnt_q == 3'd0) begin
                                if (rx_byte_d[7:6] == 2'b01) begin
                                    cmd_idx_q   <= rx_byte_d[5:0];
                                    frame_cnt_q <= 3'd1;
                                end
                            end else if (frame_cnt_q != 3'd5) begin
                                arg_q       <= {arg_q[23:0], rx_byte_d};
                                frame_cnt_q <= frame_cnt_q + 3'd1;
                            end else begin
                                frame_cnt_q   <= 3'd0;
                                resp_q        <= resp_d;
                                resp_left_q   <= resp_len_d;
                                data_cmd_q    <= data_cmd_d;
                                card_ready_q  <= card_ready_d;
                                app_cmd_q     <= app_cmd_d;
                                acmd41_seen_q <= acmd41_seen_d;
                                rd_lba_q      <= rd_lba_d;
                                state_q       <= NCR;
                                load_pend_q   <= 1'b1;
                            end
                        end
                        NCR: begin
                            state_q     <= RESP;
                            load_pend_q <= 1'b1;
                        end
                        RESP: begin
                            resp_left_q <= resp_left_q - 3'd1;
                            if (resp_left_q == 3'd1) begin
                                if (data_cmd_q) begin
                                    state_q     <= GAP;
                                    load_pend_q <= 1'b1;
                                end else begin
                                    state_q <= RX_CMD;
                                end
                            end else begin
                                load_pend_q <= 1'b1;
                            end
                        end
                        GAP: begin
                            state_q     <= TOKEN;
                            rd_index_q  <= 9'd0;
                            data_last_q <= 1'b0;
                            load_pend_q <= 1'b1;
                        end
                        TOKEN: begin
                            state_q     <= DATA;
                            load_pend_q <= 1'b1;
                        end
                        DATA: begin
                            if (data_last_q) begin
                                state_q    <= CRC;
                                crc_last_q <= 1'b0;
                            end
                            load_pend_q <= 1'b1;
                        end
                        CRC: begin
                            if (crc_last_q) begin
                                state_q <= RX_CMD;
                                busy_q  <= 1'b0;
                            end else begin
                                crc_last_q  <= 1'b1;
                                load_pend_q <= 1'b1;
                            end
                        end
                        default: state_q <= RX_CMD;
                    endcase
                end

                if (sclk_fall) begin
                    if (load_pend_q) begin
                        load_pend_q <= 1'b0;
                        miso_q      <= tx_byte_d[7];
                        tx_sr_q     <= {tx_byte_d[6:0], 1'b1};
                        tx_act_q    <= 1'b1;
                        if (state_q == RESP) begin
                            resp_q <= {resp_q[31:0], 8'hFF};
                            if (data_cmd_q) begin
                                busy_q <= 1'b1;
                            end
                        end
                        // Advancing the address right after the load gives
                        // the storage a whole byte time before the next load.
                        if (state_q == DATA) begin
                            if (rd_index_q == 9'd511) begin
                                data_last_q <= 1'b1;
                            end else begin
                                rd_index_q <= rd_index_q + 9'd1;
                            end
                        end
                    end else if (tx_act_q && bit_cnt_q != 3'd0) begin
                        miso_q  <= tx_sr_q[7];
                        tx_sr_q <= {tx_sr_q[6:0], 1'b1};
                    end else begin
                        miso_q   <= 1'b1;
                        tx_act_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign spi_miso   = miso_q;
    assign rd_lba     = rd_lba_q;
    assign rd_index   = rd_index_q;
    assign card_ready = card_ready_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_sd_spi_responder
//   Drives SPI mode-0 transactions at the fastest supported SCLK (8 clk per
//   period) and compares MISO bytes and status against a command-level
//   reference model of an SD card in SPI mode.
// ---------------------------------------------------------------------------
module tb_sd_spi_responder;

    localparam int HALF = 4;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [31:0] rd_lba;
    logic [8:0]  rd_index;
    logic [7:0]  rd_data;
    logic        card_ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Reference card state
    bit          m_ready;
    bit          m_app;
    bit          m_seen;
    logic [31:0] m_lba;
    logic [7:0]  exp_q[$];
    bit          exp_data;

    logic        mid_busy;
    logic [8:0]  mid_idx;

    int sel_tab[10] = '{55, 41, 55, 41, 8, 58, 17, 17, 9, 0};

    sd_spi_responder dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .rd_lba      (rd_lba),
        .rd_index    (rd_index),
        .rd_data     (rd_data),
        .card_ready  (card_ready),
        .busy        (busy)
    );

    always #5 clk_clk = ~clk_clk;

    // Storage: byte value equals index[7:0], one clock of read latency.
    always @(posedge clk_clk) rd_data <= rd_index[7:0];

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic half_period();
        wait_clk(HALF);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            half_period();
            rx[i] = spi_miso;
            if (i == 4) begin
                mid_busy = busy;
                mid_idx  = rd_index;
            end
            spi_sclk = 1'b1;
            half_period();
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_bits(input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi = 1'b0;
            half_period();
            spi_sclk = 1'b1;
            half_period();
            spi_sclk = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_ready = 0;
        m_app   = 0;
        m_seen  = 0;
        m_lba   = 32'd0;
    endtask

    // Card behaviour per command: fills exp_q with the bytes after NCR.
    task automatic model_cmd(input int idx, input logic [31:0] arg);
        logic [7:0] r1;
        r1 = m_ready ? 8'h00 : 8'h01;
        exp_q.delete();
        exp_data = 0;
        if (idx == 0) begin
            exp_q.push_back(8'h01);
            m_ready = 0;
            m_seen  = 0;
        end else if (idx == 8) begin
            exp_q = '{r1, 8'h00, 8'h00, {4'h0, arg[11:8]}, arg[7:0]};
        end else if (idx == 55) begin
            exp_q.push_back(r1);
        end else if (idx == 41 && m_app) begin
            if (!m_seen) begin
                exp_q.push_back(8'h01);
                m_seen = 1;
            end else begin
                exp_q.push_back(8'h00);
                m_ready = 1;
            end
        end else if (idx == 58) begin
            exp_q = '{r1, 8'hC0, 8'hFF, 8'h80, 8'h00};
        end else if (idx == 17 && m_ready) begin
            exp_q.push_back(8'h00);
            exp_data = 1;
            m_lba    = arg;
        end else begin
            exp_q.push_back(8'h04 | r1);
        end
        m_app = (idx == 55);
    endtask

    // One full command exchange. data_limit < 512 deselects mid-byte after
    // that many data bytes.
    task automatic do_cmd(input string name, input int idx, input logic [31:0] arg,
                          input int data_limit);
        logic [7:0] frame[6];
        logic [7:0] rx;
        logic [7:0] ev;
        logic [8:0] ei;
        model_cmd(idx, arg);
        frame = '{{2'b01, idx[5:0]}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], 8'h95};
        for (int i = 0; i < 6; i++) begin
            spi_byte(frame[i], rx);
            checks++;
            if (rx !== 8'hFF || mid_busy !== 1'b0) begin
                failures++;
                $display("FAIL %s frame byte %0d: miso=%h busy=%b, expected FF busy=0",
                         name, i, rx, mid_busy);
            end
        end
        spi_byte(8'hFF, rx);
        checks++;
        if (rx !== 8'hFF || mid_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s ncr: miso=%h busy=%b, expected FF busy=0", name, rx, mid_busy);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            spi_byte(8'hFF, rx);
            checks++;
            if (rx !== exp_q[k] || mid_busy !== exp_data) begin
                failures++;
                $display("FAIL %s resp byte %0d: miso=%h busy=%b, expected %h busy=%b",
                         name, k, rx, mid_busy, exp_q[k], exp_data);
            end
        end
        if (exp_data) begin
            spi_byte(8'hFF, rx);
            checks++;
            if (rx !== 8'hFF || mid_busy !== 1'b1) begin
                failures++;
                $display("FAIL %s gap: miso=%h busy=%b, expected FF busy=1", name, rx, mid_busy);
            end
            spi_byte(8'hFF, rx);
            checks++;
            if (rx !== 8'hFE || mid_busy !== 1'b1 || mid_idx !== 9'd0) begin
                failures++;
                $display("FAIL %s token: miso=%h busy=%b idx=%0d, expected FE busy=1 idx=0",
                         name, rx, mid_busy, mid_idx);
            end
            for (int j = 0; j < 512 && j < data_limit; j++) begin
                spi_byte(8'hFF, rx);
                ev = j[7:0];
                ei = (j == 511) ? 9'd511 : 9'(j + 1);
                checks++;
                if (rx !== ev || mid_busy !== 1'b1 || mid_idx !== ei) begin
                    failures++;
                    $display("FAIL %s data %0d: miso=%h busy=%b idx=%0d, expected %h busy=1 idx=%0d",
                             name, j, rx, mid_busy, mid_idx, ev, ei);
                end
            end
            checks++;
            if (rd_lba !== m_lba) begin
                failures++;
                $display("FAIL %s rd_lba: got %h, expected %h", name, rd_lba, m_lba);
            end
            if (data_limit < 512) begin
                spi_bits(4);
                spi_cs_n = 1'b1;
                spi_bits(2);
                wait_clk(4);
                checks++;
                if (spi_miso !== 1'b1 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL %s abort: miso=%b busy=%b, expected miso=1 busy=0",
                             name, spi_miso, busy);
                end
                checks++;
                if (card_ready !== m_ready) begin
                    failures++;
                    $display("FAIL %s abort card_ready: got %b, expected %b",
                             name, card_ready, m_ready);
                end
                spi_cs_n = 1'b0;
                wait_clk(6);
                return;
            end
            for (int c = 0; c < 2; c++) begin
                spi_byte(8'hFF, rx);
                checks++;
                if (rx !== 8'hFF || mid_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s crc %0d: miso=%h busy=%b, expected FF busy=1",
                             name, c, rx, mid_busy);
                end
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL %s busy after crc: got %b, expected 0", name, busy);
            end
        end
        spi_byte(8'hFF, rx);
        checks++;
        if (rx !== 8'hFF || mid_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle after response: miso=%h busy=%b, expected FF busy=0",
                     name, rx, mid_busy);
        end
        checks++;
        if (card_ready !== m_ready) begin
            failures++;
            $display("FAIL %s card_ready: got %b, expected %b", name, card_ready, m_ready);
        end
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        spi_cs_n    = 1'b0;
        spi_mosi    = 1'b1;
        spi_sclk    = 1'b0;
        model_reset();
        wait_clk(3);
        spi_bits(3);
        checks++;
        if (spi_miso !== 1'b1 || busy !== 1'b0 || card_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset status: miso=%b busy=%b ready=%b, expected 1 0 0",
                     spi_miso, busy, card_ready);
        end
        checks++;
        if (rd_lba !== 32'd0 || rd_index !== 9'd0) begin
            failures++;
            $display("FAIL reset address: lba=%h index=%0d, expected 0 0", rd_lba, rd_index);
        end
        reset_reset = 1'b0;
        wait_clk(6);
    endtask

    task automatic test_cmd0();
        do_cmd("cmd0", 0, 32'h0, 512);
    endtask

    task automatic test_cmd17_uninit();
        do_cmd("cmd17_uninit", 17, 32'h5, 512);
    endtask

    task automatic test_cmd8();
        do_cmd("cmd8", 8, 32'h0000_01AA, 512);
    endtask

    task automatic test_init();
        do_cmd("cmd55_a", 55, 32'h0, 512);
        do_cmd("acmd41_a", 41, 32'h4000_0000, 512);
        do_cmd("cmd55_b", 55, 32'h0, 512);
        do_cmd("acmd41_b", 41, 32'h4000_0000, 512);
        checks++;
        if (card_ready !== 1'b1) begin
            failures++;
            $display("FAIL init card_ready: got %b, expected 1", card_ready);
        end
    endtask

    task automatic test_cmd17_full();
        do_cmd("cmd17_full", 17, 32'h5, 512);
    endtask

    task automatic test_unknown();
        do_cmd("cmd9", 9, 32'h0, 512);
        do_cmd("cmd41_no_app", 41, 32'h0, 512);
    endtask

    task automatic test_cs_abort();
        do_cmd("cmd17_abort", 17, 32'h0000_1234, 100);
        do_cmd("cmd58_after_abort", 58, 32'h0, 512);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] rx;
        spi_byte(8'h7A, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_bits(3);
        reset_reset = 1'b1;
        model_reset();
        wait_clk(3);
        checks++;
        if (spi_miso !== 1'b1 || busy !== 1'b0 || card_ready !== 1'b0 || rd_lba !== 32'd0) begin
            failures++;
            $display("FAIL midframe reset: miso=%b busy=%b ready=%b lba=%h, expected 1 0 0 0",
                     spi_miso, busy, card_ready, rd_lba);
        end
        reset_reset = 1'b0;
        wait_clk(6);
        do_cmd("cmd58_after_reset", 58, 32'h0, 512);
    endtask

    task automatic test_random();
        logic [7:0] rx;
        logic [7:0] b;
        int idx;
        int nfill;
        for (int it = 0; it < 10; it++) begin
            nfill = $urandom_range(0, 2);
            for (int f = 0; f < nfill; f++) begin
                b = 8'($urandom);
                if (b[7:6] == 2'b01) b[7] = 1'b1;
                spi_byte(b, rx);
                checks++;
                if (rx !== 8'hFF) begin
                    failures++;
                    $display("FAIL random filler %h: miso=%h, expected FF", b, rx);
                end
            end
            idx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 63))
                                              : sel_tab[$urandom_range(0, 9)];
            do_cmd($sformatf("random%0d_cmd%0d", it, idx), idx, $urandom,
                   int'($urandom_range(1, 6)));
        end
    endtask

    initial begin
        wait_clk(150000);
        $display("FAIL watchdog: run exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cmd0();
        test_cmd17_uninit();
        test_cmd8();
        test_init();
        test_cmd17_full();
        test_unknown();
        test_cs_abort();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_spi_responder.md
SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk_clk input 1 (system clock, all logic rising-edge); reset_reset input 1 (async assert, active-high).
REQ-002 The block SHALL provide these SPI ports: spi_sclk input 1 (SPI clock from the card-interface master); spi_cs_n input 1 (chip select, active-low); spi_mosi input 1 (master-out data); spi_miso output 1 (responder-out data).
REQ-003 The block SHALL provide these block-storage ports: rd_lba output 32 (block address from the CMD17 argument); rd_index output 9 (byte index within the block); rd_data input 8 (byte at rd_lba/rd_index, valid 1 clk after the address changes).
REQ-004 The block SHALL provide these status ports: card_ready output 1 (initialization complete); busy output 1 (CMD17 transfer in progress).

Function
REQ-005 The block SHALL pass spi_sclk, spi_cs_n and spi_mosi through 2-flop synchronizers and detect SCLK edges in the clk_clk domain; operation is supported for SCLK period >= 8 clk_clk.
REQ-006 The SPI protocol SHALL be mode 0, MSB first: MOSI sampled on the synchronized SCLK rise, MISO updated on the synchronized SCLK fall.
REQ-007 spi_miso SHALL be 1 whenever no byte is scheduled and whenever spi_cs_n is high.
REQ-008 The state machine SHALL use states RX_CMD, NCR, RESP, GAP, TOKEN, DATA, CRC.
REQ-009 In RX_CMD, a byte with bits[7:6]=01 SHALL start a 6-byte frame (index, arg[31:0], crc); other bytes are discarded; the crc byte is not checked.
REQ-010 After the 6th frame byte, the block SHALL send one 0xFF byte (NCR) and then the response from RESP.
REQ-011 Responses SHALL be: CMD0 -> R1 0x01, and card_ready cleared.
REQ-012 CMD8 SHALL respond 0x01,0x00,0x00,arg[11:8],arg[7:0], with card_ready=0; the same 5 bytes with the first byte 0x00 once card_ready=1.
REQ-013 CMD55 SHALL respond R1 = {7'b0,~card_ready} and set an app_cmd flag.
REQ-014 ACMD41 (CMD41 with app_cmd set) SHALL respond 0x01 on its first occurrence after reset or CMD0; the second occurrence SHALL respond 0x00 and set card_ready.
REQ-015 CMD58 SHALL respond R1 followed by OCR 0xC0,0xFF,0x80,0x00.
REQ-016 CMD17 with card_ready=1 SHALL respond R1 0x00, one 0xFF byte (GAP), token 0xFE, 512 bytes of rd_data (index 0..511), then 2 CRC bytes 0xFF,0xFF, and return to RX_CMD.
REQ-017 CMD17 with card_ready=0, CMD41 without app_cmd, and any other index SHALL respond R1 = 0x04|{7'b0,~card_ready}, with no data phase.
REQ-018 app_cmd SHALL be cleared by any command other than CMD55.
REQ-019 rd_lba SHALL latch arg at CMD17 acceptance; rd_index SHALL hold 0 at TOKEN and increment after each data byte is loaded, so each address leads its byte load by >= 2 clk.
REQ-020 Each outgoing byte SHALL be loaded into the shifter on the SCLK fall following the 8th rise of the previous byte; bit 7 is driven on that fall.
REQ-021 busy SHALL be 1 from CMD17 R1 load through the last CRC bit, and 0 otherwise.
REQ-022 MOSI SHALL be ignored in NCR through CRC; commands arriving there are lost.
REQ-023 spi_cs_n rising at any point SHALL abort: return to RX_CMD, clear the bit counter, clear busy, drive MISO 1; card_ready and app_cmd are retained.
REQ-024 An SCLK edge while spi_cs_n is high SHALL be ignored.
REQ-025 The bit counter SHALL wrap 7->0 with no lost edge; rd_index SHALL not exceed 511.

Reset
REQ-026 Reset assertion SHALL force RX_CMD, spi_miso=1, card_ready=0, busy=0, rd_lba=0, rd_index=0, app_cmd=0, and clear the counters and shifters, regardless of SPI activity.
REQ-027 After reset deassertion, the first valid frame start SHALL be recognized with no extra dummy bytes required.

Verification
REQ-028 CMD0 frame 40 00 00 00 00 95 -> MISO bytes FF then 01; card_ready=0.
REQ-029 CMD8 arg 0x000001AA -> FF,01,00,00,01,AA.
REQ-030 CMD55, ACMD41, CMD55, ACMD41 -> R1 01,01,01,00; card_ready=1 after the 4th.
REQ-031 CMD17 arg 0x00000005 (ROM byte = index[7:0]) -> 00,FF,FE,00..FF,00..FF,FF,FF; rd_lba=5; busy spans R1..CRC.
REQ-032 CMD17 before init -> R1 05, no token; unknown CMD9 after init -> R1 04.
REQ-033 spi_cs_n high at data byte 100, and separately reset asserted mid-frame -> MISO=1, busy=0, next CMD58 answered correctly (R1 + C0 FF 80 00).
